// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
//  Shared types and constants for the fetch front-end.
//  WORD_W        : datapath / address width
//  INSTR_BYTES   : bytes per instruction (PC increment)
//  fetch_state_e : fetch FSM states
//  fetch_entry_t : one buffered instruction with the address it came from
//  align_word()  : clears the byte-offset bits of an address
// ---------------------------------------------------------------------------
package mips_pkg;

    localparam int WORD_W      = 32;
    localparam int INSTR_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FLUSH = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] instr;
    } fetch_entry_t;

    function automatic logic [WORD_W-1:0] align_word(input logic [WORD_W-1:0] addr);
        return {addr[WORD_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo
//  Small circular queue of fetch_entry_t used between instruction memory
//  responses and decode. Head is visible combinationally; writes are
//  registered. Push and pop in the same cycle are allowed, including when
//  full. Flush empties the queue and overrides push/pop.
//  Ports:
//   clk        in  clock
//   rst        in  asynchronous active-low reset
//   flush      in  discard all entries
//   push       in  write push_data at the tail
//   push_data  in  entry to write
//   pop        in  drop the head entry (ignored when empty)
//   head       out entry at the head (contents undefined when empty)
//   count      out number of valid entries, 0..DEPTH
//   full       out count == DEPTH
//   empty      out count == 0
// ---------------------------------------------------------------------------
module fetch_fifo
    import mips_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int CW   = $clog2(DEPTH + 1),
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    output fetch_entry_t head,
    output logic [CW-1:0] count,
    output logic         full,
    output logic         empty
);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CW'(DEPTH));
    assign count   = count_reg;
    assign do_pop  = pop && !empty;
    // A pop frees the slot the push needs, so full does not block push then.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr_reg];

    // Storage has no reset; entries are only observed while counted valid.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            always_ff @(posedge clk) begin
                if (do_push && !flush && (wr_ptr_reg == AW'(gi))) begin
                    mem[gi] <= push_data;
                end
            end
        end
    endgenerate

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//  Fetch stage: owns the fetch PC, issues in-order instruction memory
//  requests under a credit limit of DEPTH (outstanding + buffered), buffers
//  returned words with their PCs in fetch_fifo and presents them to decode
//  over valid/ready. A redirect flushes the queue, restarts fetch at the new
//  PC and drops every response still in flight at that point.
//  Optional build macro IFU_BYPASS_EN: a kept response arriving while the
//  queue is empty is shown to decode in the same cycle (and not queued if
//  decode takes it). Without the macro every response is queued first.
//  Ports:
//   clk, rst        clock; asynchronous active-low reset
//   imem_req_valid  out  fetch request valid
//   imem_req_ready  in   memory accepts request
//   imem_req_addr   out  word-aligned fetch address
//   imem_rsp_valid  in   in-order response valid
//   imem_rsp_data   in   instruction word
//   redirect_valid  in   taken branch/jump: flush and restart
//   redirect_pc     in   restart address, bits [1:0] ignored
//   out_valid       out  instruction available to decode
//   out_ready       in   decode consumes this cycle
//   out_instr       out  instruction word (0 when nothing valid)
//   out_pc          out  address of out_instr
//   pc_out          out  current fetch PC
// ---------------------------------------------------------------------------
module instr_fetch_unit
    import mips_pkg::*;
#(
    parameter int                DEPTH    = 4,
    parameter logic [WORD_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [WORD_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [WORD_W-1:0] imem_rsp_data,
    input  logic              redirect_valid,
    input  logic [WORD_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_instr,
    output logic [WORD_W-1:0] out_pc,
    output logic [WORD_W-1:0] pc_out
);

    localparam int CW = $clog2(DEPTH + 1);

    fetch_state_e      state_reg, state_next;
    logic [WORD_W-1:0] fetch_pc_reg, fetch_pc_next;
    logic [WORD_W-1:0] rsp_pc_reg, rsp_pc_next;
    logic [CW-1:0]     inflight_reg, inflight_next;
    logic [CW-1:0]     drop_cnt_reg, drop_cnt_next;

    logic [CW-1:0]     fifo_count;
    logic              fifo_empty;
    logic              unused_fifo_full;
    fetch_entry_t      fifo_head;
    fetch_entry_t      push_entry;
    logic              fifo_push;
    logic              fifo_pop;

    logic [CW:0]       credit_sum;
    logic              req_accept;
    logic              rsp_drop;
    logic              rsp_keep;
    logic              bypass_valid;

    // Credits cover both in-flight requests and queued words, so a kept
    // response always has a queue slot.
    assign credit_sum     = {1'b0, inflight_reg} + {1'b0, fifo_count};
    assign imem_req_valid = (state_reg != IDLE) && !redirect_valid
                            && (credit_sum < (CW+1)'(DEPTH));
    assign imem_req_addr  = fetch_pc_reg;
    assign pc_out         = fetch_pc_reg;
    assign req_accept     = imem_req_valid && imem_req_ready;

    // Responses still owed from before the last redirect are discarded, as
    // is any response landing in a redirect cycle.
    assign rsp_drop = imem_rsp_valid && (drop_cnt_reg != '0);
    assign rsp_keep = imem_rsp_valid && (drop_cnt_reg == '0) && !redirect_valid;

`ifdef IFU_BYPASS_EN
    assign bypass_valid = fifo_empty && rsp_keep;
`else
    assign bypass_valid = 1'b0;
`endif

    assign out_valid = !fifo_empty || bypass_valid;
    assign out_instr = !fifo_empty  ? fifo_head.instr :
                       bypass_valid ? imem_rsp_data   : '0;
    // With nothing queued, rsp_pc_reg is the PC of the next word decode sees.
    assign out_pc    = !fifo_empty ? fifo_head.pc : rsp_pc_reg;

    assign push_entry.pc    = rsp_pc_reg;
    assign push_entry.instr = imem_rsp_data;
    assign fifo_push        = rsp_keep && !(bypass_valid && out_ready);
    assign fifo_pop         = !fifo_empty && out_ready && !redirect_valid;

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (unused_fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        state_next    = state_reg;
        fetch_pc_next = fetch_pc_reg;
        rsp_pc_next   = rsp_pc_reg;
        inflight_next = inflight_reg;
        drop_cnt_next = drop_cnt_reg;

        if (req_accept && !imem_rsp_valid) begin
            inflight_next = inflight_reg + CW'(1);
        end else if (!req_accept && imem_rsp_valid) begin
            inflight_next = inflight_reg - CW'(1);
        end

        if (req_accept) begin
            fetch_pc_next = fetch_pc_reg + WORD_W'(INSTR_BYTES);
        end
        if (rsp_keep) begin
            rsp_pc_next = rsp_pc_reg + WORD_W'(INSTR_BYTES);
        end
        if (rsp_drop) begin
            drop_cnt_next = drop_cnt_reg - CW'(1);
        end

        case (state_reg)
            IDLE:    state_next = FETCH;
            FETCH:   state_next = FETCH;
            FLUSH:   state_next = (drop_cnt_next == '0) ? FETCH : FLUSH;
            default: state_next = IDLE;
        endcase

        // Everything still in flight after this cycle's accounting belongs
        // to the old path; later requests are on the new path and are kept.
        if (redirect_valid) begin
            fetch_pc_next = align_word(redirect_pc);
            rsp_pc_next   = align_word(redirect_pc);
            drop_cnt_next = inflight_next;
            state_next    = (inflight_next != '0) ? FLUSH : FETCH;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IDLE;
            fetch_pc_reg <= RESET_PC;
            rsp_pc_reg   <= RESET_PC;
            inflight_reg <= '0;
            drop_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            fetch_pc_reg <= fetch_pc_next;
            rsp_pc_reg   <= rsp_pc_next;
            inflight_reg <= inflight_next;
            drop_cnt_reg <= drop_cnt_next;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_unit
//  Inputs are driven just after the falling edge and outputs sampled 1 time
//  unit later. The memory model returns word_at(addr) in request order.
//  The reference is the architectural view: decode must see one unbroken
//  ascending PC stream that restarts at each redirect target, and requests
//  must walk the same way.
// ---------------------------------------------------------------------------
module tb_instr_fetch_unit;
    import mips_pkg::*;

    localparam int DEPTH = 4;
`ifdef IFU_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data  = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc    = '0;
    logic        out_valid;
    logic        out_ready      = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] pc_out;

    always #5 clk = ~clk;

    instr_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .pc_out         (pc_out)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int pops  = 0;
    int lat_max = 0;

    typedef struct { logic [31:0] addr; int due; } pend_t;
    pend_t pend[$];

    logic [31:0] exp_req = '0;
    logic [31:0] exp_out = '0;

    logic        s_req_valid, s_out_valid, s_acc, s_pop;
    logic [31:0] s_req_addr, s_out_pc;

    typedef struct {
        bit rr; bit rsp; bit redir; logic [31:0] rpc; bit ordy;
        bit e_rv; logic [31:0] e_ra;
        bit e_ov_nb; logic [31:0] e_pc_nb;
        bit e_ov_bp; logic [31:0] e_pc_bp;
    } vec_t;
    vec_t vecs[12];

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    function automatic vec_t mk(input bit rr, input bit rsp, input bit redir, input logic [31:0] rpc,
                                input bit ordy, input bit e_rv, input logic [31:0] e_ra,
                                input bit ov_nb, input logic [31:0] pc_nb,
                                input bit ov_bp, input logic [31:0] pc_bp);
        vec_t v;
        v.rr = rr; v.rsp = rsp; v.redir = redir; v.rpc = rpc; v.ordy = ordy;
        v.e_rv = e_rv; v.e_ra = e_ra;
        v.e_ov_nb = ov_nb; v.e_pc_nb = pc_nb; v.e_ov_bp = ov_bp; v.e_pc_bp = pc_bp;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // One clock cycle: drive, sample, update the reference, advance.
    task automatic tick(input bit rr, input bit rsp_en, input bit redir,
                        input logic [31:0] rpc, input bit ordy);
        bit rsp;
        rsp = rsp_en && (pend.size() > 0) && (pend[0].due <= cyc);
        imem_req_ready = rr;
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? word_at(pend[0].addr) : 32'hDEAD_BEEF;
        redirect_valid = redir;
        redirect_pc    = rpc;
        out_ready      = ordy;
        #1;
        s_req_valid = imem_req_valid;
        s_req_addr  = imem_req_addr;
        s_out_valid = out_valid;
        s_out_pc    = out_pc;
        s_acc       = imem_req_valid && rr;
        s_pop       = out_valid && ordy && !redir;
        if (redir) chk("no_req_on_redirect", {31'd0, imem_req_valid}, 32'd0);
        if (s_acc) begin
            chk("req_addr", imem_req_addr, exp_req);
            exp_req = exp_req + 32'd4;
        end
        if (s_pop) begin
            chk("out_pc", out_pc, exp_out);
            chk("out_instr", out_instr, word_at(out_pc));
            $display("xfer cycle=%0d pc=%08h instr=%08h", cyc, out_pc, out_instr);
            exp_out = exp_out + 32'd4;
            pops++;
        end
        if (redir) begin
            exp_req = {rpc[31:2], 2'b00};
            exp_out = {rpc[31:2], 2'b00};
        end
        if (rsp) void'(pend.pop_front());
        if (s_acc) pend.push_back('{addr: imem_req_addr, due: cyc + 1 + int'($urandom_range(0, lat_max))});
        chk("outstanding_limit", {31'd0, pend.size() <= DEPTH}, 32'd1);
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        imem_req_ready = 0; imem_rsp_valid = 0; redirect_valid = 0; out_ready = 0;
        pend.delete();
        exp_req = '0;
        exp_out = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst req_valid", {31'd0, imem_req_valid}, 32'd0);
        chk("rst out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst out_instr", out_instr, 32'd0);
        chk("rst out_pc", out_pc, 32'd0);
        chk("rst pc_out", pc_out, 32'd0);
        chk("rst req_addr", imem_req_addr, 32'd0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int acc_cnt;
        int npop;
        bit found;
        logic [31:0] got[5];
        logic [31:0] rpc;

        // Directed cycle table: startup streaming, bypass latency, redirect
        // with two requests in flight.
        vecs[0]  = mk(0,0,0,32'h0,  0, 0,32'h0,   0,32'h0,   0,32'h0);
        vecs[1]  = mk(1,0,0,32'h0,  1, 1,32'h0,   0,32'h0,   0,32'h0);
        vecs[2]  = mk(1,1,0,32'h0,  1, 1,32'h4,   0,32'h0,   1,32'h0);
        vecs[3]  = mk(0,1,0,32'h0,  1, 1,32'h8,   1,32'h0,   1,32'h4);
        vecs[4]  = mk(1,0,0,32'h0,  0, 1,32'h8,   1,32'h4,   0,32'h0);
        vecs[5]  = mk(1,0,0,32'h0,  0, 1,32'hC,   1,32'h4,   0,32'h0);
        vecs[6]  = mk(1,0,1,32'h105,1, 0,32'h0,   1,32'h4,   0,32'h0);
        vecs[7]  = mk(1,1,0,32'h0,  1, 1,32'h104, 0,32'h0,   0,32'h0);
        vecs[8]  = mk(0,1,0,32'h0,  1, 1,32'h108, 0,32'h0,   0,32'h0);
        vecs[9]  = mk(0,1,0,32'h0,  0, 1,32'h108, 0,32'h0,   1,32'h104);
        vecs[10] = mk(0,0,0,32'h0,  1, 1,32'h108, 1,32'h104, 1,32'h104);
        vecs[11] = mk(0,0,0,32'h0,  1, 1,32'h108, 0,32'h0,   0,32'h0);

        do_reset();
        for (int i = 0; i < 12; i++) begin
            bit eov;
            logic [31:0] epc;
            tick(vecs[i].rr, vecs[i].rsp, vecs[i].redir, vecs[i].rpc, vecs[i].ordy);
            eov = BYPASS ? vecs[i].e_ov_bp : vecs[i].e_ov_nb;
            epc = BYPASS ? vecs[i].e_pc_bp : vecs[i].e_pc_nb;
            $display("vec %0d req_valid=%0d addr=%08h out_valid=%0d out_pc=%08h",
                     i, s_req_valid, s_req_addr, s_out_valid, s_out_pc);
            chk($sformatf("vec%0d req_valid", i), {31'd0, s_req_valid}, {31'd0, vecs[i].e_rv});
            if (vecs[i].e_rv) chk($sformatf("vec%0d req_addr", i), s_req_addr, vecs[i].e_ra);
            chk($sformatf("vec%0d out_valid", i), {31'd0, s_out_valid}, {31'd0, eov});
            if (eov) chk($sformatf("vec%0d out_pc", i), s_out_pc, epc);
        end

        // Decode stalled: credits cap acceptance at DEPTH, head holds.
        do_reset();
        acc_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1, 1, 0, 32'h0, 0);
            if (s_acc) acc_cnt++;
        end
        $display("stall accepts=%0d req_valid=%0d out_pc=%08h", acc_cnt, s_req_valid, s_out_pc);
        chk("stall accepts", acc_cnt, 4);
        chk("stall req_valid", {31'd0, s_req_valid}, 32'd0);
        chk("stall out_valid", {31'd0, s_out_valid}, 32'd1);
        chk("stall out_pc", s_out_pc, 32'd0);
        npop = 0;
        for (int k = 0; k < 5; k++) got[k] = 32'hFFFF_FFFF;
        for (int i = 0; i < 30 && npop < 5; i++) begin
            tick(1, 1, 0, 32'h0, 1);
            if (s_pop) begin got[npop] = s_out_pc; npop++; end
        end
        for (int k = 0; k < 5; k++) chk($sformatf("release pop%0d", k), got[k], 32'(k * 4));

        // Redirect coinciding with a response and a pop attempt.
        do_reset();
        tick(1, 0, 0, 32'h0, 0);
        tick(1, 0, 0, 32'h0, 0);
        tick(1, 1, 0, 32'h0, 0);
        tick(1, 0, 0, 32'h0, 0);
        tick(1, 1, 1, 32'h200, 1);
        chk("redir head visible", {31'd0, s_out_valid}, 32'd1);
        tick(0, 0, 0, 32'h0, 1);
        chk("after redir empty", {31'd0, s_out_valid}, 32'd0);
        tick(1, 1, 0, 32'h0, 1);
        chk("dropped rsp hidden", {31'd0, s_out_valid}, 32'd0);
        found = 0;
        for (int i = 0; i < 6 && !found; i++) begin
            tick(0, 1, 0, 32'h0, 1);
            if (s_pop) begin
                found = 1;
                chk("first after redir", s_out_pc, 32'h200);
            end
        end
        chk("redir target delivered", {31'd0, found}, 32'd1);

        // Asynchronous reset mid-stream with words buffered.
        for (int i = 0; i < 6; i++) tick(1, 1, 0, 32'h0, 0);
        chk("pre-reset buffered", {31'd0, s_out_valid}, 32'd1);
        #2;
        rst = 1'b0;
        imem_req_ready = 0; imem_rsp_valid = 0; out_ready = 0;
        #1;
        chk("async out_valid", {31'd0, out_valid}, 32'd0);
        chk("async req_addr", imem_req_addr, 32'd0);
        chk("async pc_out", pc_out, 32'd0);
        pend.delete();
        exp_req = '0;
        exp_out = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        found = 0;
        for (int i = 0; i < 5 && !found; i++) begin
            tick(1, 1, 0, 32'h0, 1);
            if (s_acc) begin
                found = 1;
                chk("refetch addr", s_req_addr, 32'h0);
            end
        end
        chk("refetch issued", {31'd0, found}, 32'd1);

        // Randomized traffic against the stream model.
        lat_max = 3;
        npop = pops;
        for (int i = 0; i < 3000; i++) begin
            bit redir;
            redir = ($urandom_range(0, 99) < 3);
            if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            else rpc = $urandom;
            tick($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7, redir, rpc,
                 $urandom_range(0, 9) < 7);
        end
        chk("random progress", {31'd0, (pops - npop) > 200}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
